// File: rtl/float_pkg.sv
// Shared binary32 field widths, exponent bias and the packed word layout used by the
// fixed-to-float operand path.
package float_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/leading_one_detector.sv
// Reports the bit index of the most significant set bit of vec, plus a flag for vec == 0
// (index reads 0 in that case).
module leading_one_detector #(
    parameter int WIDTH = 16,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             zero
);

    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) index = IDX_W'(i);
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/fixed_to_float_converter.sv
// Two-stage signed fixed-point to binary32 converter with valid/ready on both sides.
// Define FIXED_TO_FLOAT_RNE_EN for round-to-nearest-even on wide inputs; default truncates.
module fixed_to_float_converter
    import float_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0 = 16,
    parameter int DATA_IN_0_PRECISION_1 = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [31:0]                      data_out_0,
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready
);

    localparam int W      = DATA_IN_0_PRECISION_0;
    localparam int F      = DATA_IN_0_PRECISION_1;
    localparam int IDX_W  = (W > 1) ? $clog2(W) : 1;
    localparam int NORM_W = W + FP32_MAN_W + 1;

`ifdef FIXED_TO_FLOAT_RNE_EN
    function automatic logic [FP32_MAN_W:0] round_man(input logic [FP32_MAN_W-1:0] man,
                                                      input logic guard,
                                                      input logic sticky);
        logic inc;
        inc = guard & (sticky | man[0]);
        return {inc & (&man), man + FP32_MAN_W'(inc)};
    endfunction
`else
    function automatic logic [FP32_MAN_W:0] round_man(input logic [FP32_MAN_W-1:0] man);
        return {1'b0, man};
    endfunction
`endif

    logic adv1, adv2;
    logic vld_p1, vld_p2;
    logic sign_p1;
    logic [W-1:0] mag_p1;
    fp32_t data_p2;

    assign adv2            = !vld_p2 || data_out_0_ready;
    assign adv1            = !vld_p1 || adv2;
    assign data_in_0_ready = adv1;

    // Stage 1: split sign and magnitude; -2^(W-1) maps to 2^(W-1) as unsigned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= data_in_0_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && data_in_0_valid) begin
            sign_p1 <= data_in_0[W-1];
            mag_p1  <= data_in_0[W-1] ? -data_in_0 : data_in_0;
        end
    end

    // Stage 2: normalise so the leading one sits at the top of norm, then round
    logic [IDX_W-1:0]      lead_idx;
    logic                  mag_zero;
    logic [IDX_W-1:0]      shamt;
    logic [NORM_W-1:0]     norm;
    logic [FP32_MAN_W:0]   rnd;
    logic [9:0]            exp_sum;
    fp32_t                 result;

    leading_one_detector #(
        .WIDTH (W),
        .IDX_W (IDX_W)
    ) u_lod (
        .vec   (mag_p1),
        .index (lead_idx),
        .zero  (mag_zero)
    );

    assign shamt = IDX_W'(W - 1) - lead_idx;
    assign norm  = {mag_p1, {(FP32_MAN_W + 1){1'b0}}} << shamt;

`ifdef FIXED_TO_FLOAT_RNE_EN
    // Everything below the kept 24 bits lives in norm[W-1:0]
    logic guard, sticky;
    assign guard  = norm[W-1];
    assign sticky = |norm[W-2:0];
    assign rnd    = round_man(norm[NORM_W-2 -: FP32_MAN_W], guard, sticky);
`else
    assign rnd    = round_man(norm[NORM_W-2 -: FP32_MAN_W]);
`endif

    assign exp_sum = 10'(FP32_BIAS) + 10'(lead_idx) - 10'(F) + 10'(rnd[FP32_MAN_W]);

    always_comb begin
        result = '0;
        if (!mag_zero) begin
            result.sign = sign_p1;
            result.exp  = exp_sum[FP32_EXP_W-1:0];
            result.man  = rnd[FP32_MAN_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) data_p2 <= result;
        end
    end

    assign data_out_0       = data_p2;
    assign data_out_0_valid = vld_p2;

endmodule

// File: tb/tb_fixed_to_float_converter.sv
// Randomised and directed bench for fixed_to_float_converter with two instances
// (16-bit Q8 and 32-bit integer) against an arithmetic binary32 reference.
module tb_fixed_to_float_converter;

    localparam int AW = 16, AF = 8, BW = 32, BF = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] a_din;
    logic          a_vin, a_rdy, a_vout, a_ordy;
    logic [31:0]   a_dout;
    logic [BW-1:0] b_din;
    logic          b_vin, b_rdy, b_vout, b_ordy;
    logic [31:0]   b_dout;

    int checks = 0;
    int failures = 0;

    fixed_to_float_converter #(.DATA_IN_0_PRECISION_0(AW), .DATA_IN_0_PRECISION_1(AF)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .data_in_0(a_din), .data_in_0_valid(a_vin), .data_in_0_ready(a_rdy),
        .data_out_0(a_dout), .data_out_0_valid(a_vout), .data_out_0_ready(a_ordy)
    );

    fixed_to_float_converter #(.DATA_IN_0_PRECISION_0(BW), .DATA_IN_0_PRECISION_1(BF)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .data_in_0(b_din), .data_in_0_valid(b_vin), .data_in_0_ready(b_rdy),
        .data_out_0(b_dout), .data_out_0_valid(b_vout), .data_out_0_ready(b_ordy)
    );

    // Reference: value = val / 2^f, expressed as sign * 1.m * 2^e
    function automatic logic [31:0] ref_f32(input longint val, input int f);
        longint unsigned mag, q;
        int p;
        logic s;
`ifdef FIXED_TO_FLOAT_RNE_EN
        longint unsigned rem, half;
`endif
        if (val == 0) return 32'h0;
        s   = (val < 0);
        mag = s ? longint'(-val) : longint'(val);
        p   = 0;
        while ((mag >> (p + 1)) != 0) p++;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            q = mag >> (p - 23);
`ifdef FIXED_TO_FLOAT_RNE_EN
            rem  = mag - (q << (p - 23));
            half = 64'd1 << (p - 24);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
`endif
        end
        return {s, 8'(127 + p - f), 23'(q)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_din = '0; a_vin = 1'b0; a_ordy = 1'b0;
        b_din = '0; b_vin = 1'b0; b_ordy = 1'b0;
        tick();
        tick();
        checks++;
        if (a_vout !== 1'b0) begin failures++; $display("FAIL reset_a_valid: got %b expected 0", a_vout); end
        checks++;
        if (a_dout !== 32'h0) begin failures++; $display("FAIL reset_a_data: got %h expected 00000000", a_dout); end
        checks++;
        if (b_vout !== 1'b0) begin failures++; $display("FAIL reset_b_valid: got %b expected 0", b_vout); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_rdy !== 1'b1) begin failures++; $display("FAIL reset_a_ready: got %b expected 1", a_rdy); end
        checks++;
        if (b_rdy !== 1'b1) begin failures++; $display("FAIL reset_b_ready: got %b expected 1", b_rdy); end
        tick();
    endtask

    task automatic test_directed_q8();
        logic [15:0] vin_t [5] = '{16'h0100, 16'hFF00, 16'h8000, 16'h0001, 16'h0000};
        logic [31:0] exp_t [5] = '{32'h3F80_0000, 32'hBF80_0000, 32'hC300_0000, 32'h3B80_0000, 32'h0};
        for (int i = 0; i < 5; i++) begin
            a_din = vin_t[i]; a_vin = 1'b1; a_ordy = 1'b1;
            tick();
            a_vin = 1'b0;
            checks++;
            if (a_vout !== 1'b0) begin failures++; $display("FAIL q8_latency1 #%0d: valid %b expected 0", i, a_vout); end
            tick();
            checks++;
            if (a_vout !== 1'b1 || a_dout !== exp_t[i]) begin
                failures++;
                $display("FAIL q8_value in=%h: got v=%b %h expected v=1 %h", vin_t[i], a_vout, a_dout, exp_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_rounding_int32();
        logic [31:0] vin_t [3] = '{32'h0100_0003, 32'h0100_0001, 32'h01FF_FFFF};
`ifdef FIXED_TO_FLOAT_RNE_EN
        logic [31:0] exp_t [3] = '{32'h4B80_0002, 32'h4B80_0000, 32'h4C00_0000};
`else
        logic [31:0] exp_t [3] = '{32'h4B80_0001, 32'h4B80_0000, 32'h4BFF_FFFF};
`endif
        for (int i = 0; i < 3; i++) begin
            b_din = vin_t[i]; b_vin = 1'b1; b_ordy = 1'b1;
            tick();
            b_vin = 1'b0;
            checks++;
            if (b_vout !== 1'b0) begin failures++; $display("FAIL int32_latency1 #%0d: valid %b expected 0", i, b_vout); end
            tick();
            checks++;
            if (b_vout !== 1'b1 || b_dout !== exp_t[i]) begin
                failures++;
                $display("FAIL int32_round in=%h: got v=%b %h expected v=1 %h", vin_t[i], b_vout, b_dout, exp_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_t [3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        int got = 0;
        logic drop_vin;
        a_ordy = 1'b0;
        a_vin = 1'b1; a_din = 16'h0100;
        tick();
        a_din = 16'h0200;
        tick();
        a_din = 16'h0300;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_rdy !== 1'b0) begin failures++; $display("FAIL bp_ready_low cyc%0d: got %b expected 0", k, a_rdy); end
            checks++;
            if (a_vout !== 1'b1 || a_dout !== 32'h3F80_0000) begin
                failures++;
                $display("FAIL bp_hold cyc%0d: got v=%b %h expected v=1 3f800000", k, a_vout, a_dout);
            end
            if (k < 3) tick();
        end
        a_ordy = 1'b1;
        #1;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            if (a_vout) begin
                checks++;
                if (a_dout !== exp_t[got]) begin
                    failures++;
                    $display("FAIL bp_order #%0d: got %h expected %h", got, a_dout, exp_t[got]);
                end
                got++;
            end
            drop_vin = a_vin && a_rdy;
            tick();
            if (drop_vin) a_vin = 1'b0;
        end
        checks++;
        if (got != 3) begin failures++; $display("FAIL bp_count: got %0d words expected 3", got); end
        a_vin = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight();
        a_ordy = 1'b0;
        a_vin = 1'b1; a_din = 16'h0100;
        tick();
        a_din = 16'h0200;
        tick();
        a_vin = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_vout !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", a_vout); end
        #1;
        rst_n = 1'b1;
        tick();
        a_din = 16'h0400; a_vin = 1'b1; a_ordy = 1'b1;
        tick();
        a_vin = 1'b0;
        checks++;
        if (a_vout !== 1'b0) begin failures++; $display("FAIL rst_post_lat1: valid %b expected 0", a_vout); end
        tick();
        checks++;
        if (a_vout !== 1'b1 || a_dout !== 32'h4080_0000) begin
            failures++;
            $display("FAIL rst_post_value: got v=%b %h expected v=1 40800000", a_vout, a_dout);
        end
        tick();
        checks++;
        if (a_vout !== 1'b0) begin failures++; $display("FAIL rst_post_alone: valid %b expected 0", a_vout); end
    endtask

    task automatic test_random_stream();
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic a_hold = 1'b0, b_hold = 1'b0;
        logic [31:0] a_prev = '0, b_prev = '0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            logic drain;
            drain = (cyc >= 400);
            a_vin  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
            a_din  = AW'($urandom);
            a_ordy = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            b_vin  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: b_din = $urandom;
                1: b_din = $urandom >> $urandom_range(0, 31);
                2: b_din = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : (32'h0100_0001 | ($urandom & 32'h6));
                default: b_din = ($urandom | 32'h0100_0000) & 32'h01FF_FFFF;
            endcase
            b_ordy = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (a_hold) begin
                checks++;
                if (a_vout !== 1'b1 || a_dout !== a_prev) begin
                    failures++;
                    $display("FAIL rand_a_stable: got v=%b %h expected v=1 %h", a_vout, a_dout, a_prev);
                end
            end
            if (b_hold) begin
                checks++;
                if (b_vout !== 1'b1 || b_dout !== b_prev) begin
                    failures++;
                    $display("FAIL rand_b_stable: got v=%b %h expected v=1 %h", b_vout, b_dout, b_prev);
                end
            end
            if (a_vout && a_ordy) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL rand_a_extra: got %h expected no word", a_dout);
                end else begin
                    if (a_dout !== qa[0]) begin
                        failures++;
                        $display("FAIL rand_a_value: got %h expected %h", a_dout, qa[0]);
                    end
                    void'(qa.pop_front());
                end
            end
            if (b_vout && b_ordy) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL rand_b_extra: got %h expected no word", b_dout);
                end else begin
                    if (b_dout !== qb[0]) begin
                        failures++;
                        $display("FAIL rand_b_value: got %h expected %h", b_dout, qb[0]);
                    end
                    void'(qb.pop_front());
                end
            end
            if (a_vin && a_rdy) qa.push_back(ref_f32(longint'($signed(a_din)), AF));
            if (b_vin && b_rdy) qb.push_back(ref_f32(longint'($signed(b_din)), BF));
            a_hold = a_vout && !a_ordy; a_prev = a_dout;
            b_hold = b_vout && !b_ordy; b_prev = b_dout;
            @(posedge clk);
            #1;
        end
        checks++;
        if (qa.size() != 0) begin failures++; $display("FAIL rand_a_lost: got %0d pending expected 0", qa.size()); end
        checks++;
        if (qb.size() != 0) begin failures++; $display("FAIL rand_b_lost: got %0d pending expected 0", qb.size()); end
    endtask

    initial begin
        test_reset();
        test_directed_q8();
        test_rounding_int32();
        test_backpressure();
        test_reset_midflight();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
